// File: rtl/req_line_driver.sv
// Request-line driver: binary index in over valid/ready, one-hot pending lines out,
// cleared by per-line acknowledge or by a global stall watchdog.

module req_line_lane (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_ack,
    input  logic i_clr,
    output logic o_req_d,
    output logic o_req_q
);
    logic req_q, req_d;

    // A set always wins; it never collides with an ack on the same line.
    assign req_d = (req_q & ~i_ack & ~i_clr) | i_set;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) req_q <= 1'b0;
        else          req_q <= req_d;
    end

    assign o_req_d = req_d;
    assign o_req_q = req_q;
endmodule

module req_line_driver #(
    parameter int REQ_N   = 12,
    parameter int IDX_W   = $clog2(REQ_N),
    parameter int CNT_W   = $clog2(REQ_N + 1),
    parameter int TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [REQ_N-1:0] i_ack,
    output logic [REQ_N-1:0] o_req,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err,
    output logic             o_timeout
);
    localparam int               WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam int               PAD_N   = 1 << IDX_W;
    localparam logic [IDX_W:0]   REQ_N_L = (IDX_W + 1)'(REQ_N);

    logic [REQ_N-1:0] req_q, req_d, ack_eff;
    logic [PAD_N-1:0] req_pad;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, tmo_q;
    logic             in_range, accept, stall, fire;

    function automatic logic [CNT_W-1:0] popcnt(input logic [REQ_N-1:0] v);
        popcnt = '0;
        for (int k = 0; k < REQ_N; k++) popcnt = popcnt + CNT_W'(v[k]);
    endfunction

    // Zero-padded copy so an out-of-range index never selects past the vector.
    assign req_pad  = PAD_N'(req_q);
    assign in_range = {1'b0, i_data} < REQ_N_L;
    assign o_ready  = !in_range || !req_pad[i_data];
    assign accept   = i_valid && o_ready;
    assign ack_eff  = i_ack & req_q;

    assign stall = (|req_q) && !(|ack_eff);
    assign fire  = stall && (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q + 1'b1;
        if (!stall || fire) wd_d = '0;
    end

    for (genvar g = 0; g < REQ_N; g++) begin : g_lane
        req_line_lane u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_set   (accept && in_range && (i_data == IDX_W'(g))),
            .i_ack   (ack_eff[g]),
            .i_clr   (fire),
            .o_req_d (req_d[g]),
            .o_req_q (req_q[g])
        );
    end

    assign cnt_d = popcnt(req_d);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            wd_q  <= '0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
            err_q <= accept && !in_range;
            tmo_q <= fire;
        end
    end

    assign o_req     = req_q;
    assign o_count   = cnt_q;
    assign o_err     = err_q;
    assign o_timeout = tmo_q;
endmodule
